// File: rtl/game_2048_board_tx.sv
// game_2048_board_tx
//   Snapshots the 2048 core's packed board on request and streams it as ASCII
//   text over a byte valid/ready interface, one character per tile.
//   Frame: four rows of "T S T S T S T CR LF", plus an optional trailing CR LF.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   board_state  tile exponents, tile (r,c) at bits [(r*4+c)*4 +: 4]
//   dump_req     single-cycle request to emit one frame
//   busy         high while a frame is being sent
//   tx_data      current output byte (registered)
//   tx_valid     tx_data valid, held until accepted
//   tx_ready     downstream accepts on tx_valid && tx_ready
//   frame_done   one-cycle pulse after the last byte is accepted
`timescale 1ns/1ps
module game_2048_board_tx #(
    parameter logic [7:0] ZERO_CHAR  = 8'h2E,
    parameter logic [7:0] SEP_CHAR   = 8'h20,
    parameter bit         BLANK_LINE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] board_state,
    input  logic        dump_req,
    output logic        busy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        frame_done
);
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t      state, state_nxt;
    logic [63:0] snap;
    // Row 4 is the trailing blank line; pos is the position within a row (0..8).
    logic [2:0]  row, row_nxt;
    logic [3:0]  pos, pos_nxt;
    logic        pending;
    logic        last_byte;
    logic        accept;
    logic        start_frame;

    function automatic logic [7:0] tile_char(input logic [3:0] e);
        logic [7:0] ch;
        if (e == 4'd0)
            ch = ZERO_CHAR;
        else if (e < 4'd10)
            ch = 8'h30 + {4'h0, e};
        else
            ch = 8'h37 + {4'h0, e};   // 'A' + (e - 10)
        return ch;
    endfunction

    function automatic logic [7:0] byte_at(input logic [63:0] b,
                                           input logic [2:0]  r,
                                           input logic [3:0]  p);
        logic [3:0] tile;
        logic [7:0] ch;
        // Tiles sit at even positions 0,2,4,6 -> column is p/2.
        tile = {r[1:0], p[2:1]};
        if (r[2])
            ch = (p == 4'd0) ? CR : LF;
        else if (p == 4'd7)
            ch = CR;
        else if (p == 4'd8)
            ch = LF;
        else if (p[0])
            ch = SEP_CHAR;
        else
            ch = tile_char(b[{tile, 2'b00} +: 4]);
        return ch;
    endfunction

    assign last_byte   = BLANK_LINE ? (row == 3'd4 && pos == 4'd1)
                                    : (row == 3'd3 && pos == 4'd8);
    assign accept      = (state == SEND) && tx_ready;
    assign start_frame = ((state == IDLE) && dump_req) ||
                         ((state == DONE) && (pending || dump_req));

    always_comb begin
        row_nxt = row;
        pos_nxt = pos + 4'd1;
        if (pos == 4'd8) begin
            pos_nxt = 4'd0;
            row_nxt = row + 3'd1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dump_req) state_nxt = SEND;
            SEND:    if (accept && last_byte) state_nxt = DONE;
            DONE:    state_nxt = (pending || dump_req) ? SEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy       = (state == SEND);
        tx_valid   = (state == SEND);
        frame_done = (state == DONE);
    end

    // Snapshot, byte counters, output byte register and pending request
    always_ff @(posedge clk) begin
        if (reset) begin
            snap    <= '0;
            row     <= '0;
            pos     <= '0;
            tx_data <= '0;
            pending <= 1'b0;
        end else begin
            if (start_frame) begin
                snap    <= board_state;
                row     <= '0;
                pos     <= '0;
                tx_data <= byte_at(board_state, 3'd0, 4'd0);
            end else if (accept && !last_byte) begin
                row     <= row_nxt;
                pos     <= pos_nxt;
                tx_data <= byte_at(snap, row_nxt, pos_nxt);
            end
            // A request seen in DONE starts the next frame directly, so the
            // flag is always consumed on leaving DONE.
            if (state == DONE)
                pending <= 1'b0;
            else if (state == SEND && dump_req)
                pending <= 1'b1;
        end
    end
endmodule
